// File: rtl/bin_mag_scheduler.sv
// bin_mag_scheduler
// Captures FFT bins named in a programmable slot table. For each capture it
// computes re^2 + im^2 and queues the request. Requests are fed one at a time
// to a shared iterative square-root unit. Each magnitude is written out on
// the haddr/hdata/hwe histogram port.
module bin_mag_scheduler #(
   parameter int NBINS      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int IDX_W      = 12,
   parameter int DW         = 10,
   parameter int FRAME_LAST = 4095
) (
   input  logic              clock_27mhz,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_slot,
   input  logic [IDX_W-1:0]  cfg_bin,
   input  logic              cfg_en,
   input  logic              xk_valid,
   input  logic [IDX_W-1:0]  xk_index,
   input  logic [DW-1:0]     xk_re,
   input  logic [DW-1:0]     xk_im,
   output logic [2*DW-1:0]   sq_data,
   output logic              sq_start,
   input  logic [DW-1:0]     sq_answer,
   input  logic              sq_done,
   output logic [IDX_W-1:0]  haddr,
   output logic [2:0]        hslot,
   output logic [DW-1:0]     hdata,
   output logic              hwe,
   output logic              frame_done,
   output logic              ovf,
   output logic [7:0]        ovf_count
);

   localparam int MW = 2 * DW;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LP_FRAME_LAST = IDX_W'(FRAME_LAST);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_GUARD,
      S_WAIT
   } state_t;

   // bin table
   logic [NBINS-1:0]  r_tabValid;
   logic [IDX_W-1:0]  r_tabBin [NBINS];

   // match stage
   logic              w_hit;
   logic [2:0]        w_hitSlot;
   logic signed [MW-1:0] w_reExt;
   logic signed [MW-1:0] w_imExt;
   logic signed [MW-1:0] w_re2;
   logic signed [MW-1:0] w_im2;
   logic              r_s1Valid;
   logic [2:0]        r_s1Slot;
   logic [IDX_W-1:0]  r_s1Index;
   logic [MW-1:0]     r_s1Re2;
   logic [MW-1:0]     r_s1Im2;

   // sum stage
   logic              r_s2Valid;
   logic [2:0]        r_s2Slot;
   logic [IDX_W-1:0]  r_s2Index;
   logic [MW-1:0]     r_s2Mag;

   // request FIFO
   logic [MW-1:0]     r_fifoMag  [FIFO_DEPTH];
   logic [IDX_W-1:0]  r_fifoIdx  [FIFO_DEPTH];
   logic [2:0]        r_fifoSlot [FIFO_DEPTH];
   logic [PW:0]       r_wrPtr;
   logic [PW:0]       r_rdPtr;
   logic [PW:0]       w_count;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_drop;
   logic [MW-1:0]     w_headMag;
   logic [IDX_W-1:0]  w_headIdx;
   logic [2:0]        w_headSlot;

   // engine
   state_t            r_state;
   state_t            w_next;
   logic              w_pop;
   logic              w_capture;
   logic              r_sqStart;
   logic [MW-1:0]     r_sqData;
   logic [IDX_W-1:0]  r_haddr;
   logic [2:0]        r_hslot;
   logic [DW-1:0]     r_hdata;
   logic              r_hwe;

   // overflow and frame tracking
   logic              r_ovf;
   logic [7:0]        r_ovfCount;
   logic              r_framePend;
   logic              r_frameDone;
   logic              w_frameCond;

   // A table write lands at the clock edge, so a same-cycle match sees the old entry
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_tabValid <= '0;
         for (int i = 0; i < NBINS; i++) begin
            r_tabBin[i] <= '0;
         end
      end else if (cfg_we) begin
         r_tabValid[cfg_slot] <= cfg_en;
         r_tabBin[cfg_slot]   <= cfg_bin;
      end
   end

   // Priority search: scan downward so the lowest matching slot is the one kept
   always_comb begin
      w_hit     = 1'b0;
      w_hitSlot = '0;
      for (int i = NBINS - 1; i >= 0; i--) begin
         if (xk_valid && r_tabValid[i] && (r_tabBin[i] == xk_index)) begin
            w_hit     = 1'b1;
            w_hitSlot = 3'(i);
         end
      end
   end

   assign w_reExt = {{DW{xk_re[DW-1]}}, xk_re};
   assign w_imExt = {{DW{xk_im[DW-1]}}, xk_im};
   assign w_re2   = w_reExt * w_reExt;
   assign w_im2   = w_imExt * w_imExt;

   // Stage 1 registers the winning slot and both squares; squares are never negative
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_s1Valid <= 1'b0;
         r_s1Slot  <= '0;
         r_s1Index <= '0;
         r_s1Re2   <= '0;
         r_s1Im2   <= '0;
      end else begin
         r_s1Valid <= w_hit;
         if (w_hit) begin
            r_s1Slot  <= w_hitSlot;
            r_s1Index <= xk_index;
            r_s1Re2   <= w_re2;
            r_s1Im2   <= w_im2;
         end
      end
   end

   // Stage 2 forms the squared magnitude; the worst case 2*512^2 still fits in MW bits
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_s2Valid <= 1'b0;
         r_s2Slot  <= '0;
         r_s2Index <= '0;
         r_s2Mag   <= '0;
      end else begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Slot  <= r_s1Slot;
            r_s2Index <= r_s1Index;
            r_s2Mag   <= r_s1Re2 + r_s1Im2;
         end
      end
   end

   assign w_count    = r_wrPtr - r_rdPtr;
   assign w_empty    = (r_wrPtr == r_rdPtr);
   assign w_full     = (w_count == (PW + 1)'(FIFO_DEPTH));
   assign w_push     = r_s2Valid && (!w_full || w_pop);
   assign w_drop     = r_s2Valid && w_full && !w_pop;
   assign w_headMag  = r_fifoMag[r_rdPtr[PW-1:0]];
   assign w_headIdx  = r_fifoIdx[r_rdPtr[PW-1:0]];
   assign w_headSlot = r_fifoSlot[r_rdPtr[PW-1:0]];

   // FIFO storage needs no reset; only the pointers define its contents
   always_ff @(posedge clock_27mhz) begin
      if (w_push) begin
         r_fifoMag[r_wrPtr[PW-1:0]]  <= r_s2Mag;
         r_fifoIdx[r_wrPtr[PW-1:0]]  <= r_s2Index;
         r_fifoSlot[r_wrPtr[PW-1:0]] <= r_s2Slot;
      end
   end

   // Pointer update; a push into a full FIFO is still taken when a pop frees a slot
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

   // Sticky overflow flag plus a saturating drop counter
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf      <= 1'b0;
         r_ovfCount <= '0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (r_ovfCount != 8'hFF) begin
            r_ovfCount <= r_ovfCount + 8'd1;
         end
      end
   end

   // Engine state register
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Engine sequencing; pops wait for hwe to drop so haddr/hslot hold through the write
   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && sq_done && !r_hwe) begin
               w_pop  = 1'b1;
               w_next = S_START;
            end
         end
         S_START: begin
            w_next = S_GUARD;
         end
         S_GUARD: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (sq_done) begin
               w_capture = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Engine outputs: sq_start is high during START, hwe for one cycle after WAIT
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_sqStart <= 1'b0;
         r_sqData  <= '0;
         r_haddr   <= '0;
         r_hslot   <= '0;
         r_hdata   <= '0;
         r_hwe     <= 1'b0;
      end else begin
         r_sqStart <= w_pop;
         r_hwe     <= w_capture;
         if (w_pop) begin
            r_sqData <= w_headMag;
            r_haddr  <= w_headIdx;
            r_hslot  <= w_headSlot;
         end
         if (w_capture) begin
            r_hdata <= sq_answer;
         end
      end
   end

   assign w_frameCond = r_framePend && !r_s1Valid && !r_s2Valid && w_empty &&
                        (r_state == S_IDLE) && !r_hwe;

   // A frame ends once its last bin was seen and every pending request is written out
   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_framePend <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= w_frameCond;
         if (xk_valid && (xk_index == LP_FRAME_LAST)) begin
            r_framePend <= 1'b1;
         end else if (w_frameCond) begin
            r_framePend <= 1'b0;
         end
      end
   end

   assign sq_data    = r_sqData;
   assign sq_start   = r_sqStart;
   assign haddr      = r_haddr;
   assign hslot      = r_hslot;
   assign hdata      = r_hdata;
   assign hwe        = r_hwe;
   assign frame_done = r_frameDone;
   assign ovf        = r_ovf;
   assign ovf_count  = r_ovfCount;

endmodule

// File: tb/tb_bin_mag_scheduler.sv
// Scoreboard testbench for bin_mag_scheduler with a behavioural sqrt unit.
module tb_bin_mag_scheduler;

   localparam int NBINS      = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int IDX_W      = 12;
   localparam int DW         = 10;
   localparam int FRAME_LAST = 4095;

   logic              clock_27mhz = 1'b0;
   logic              reset_n;
   logic              cfg_we;
   logic [2:0]        cfg_slot;
   logic [IDX_W-1:0]  cfg_bin;
   logic              cfg_en;
   logic              xk_valid;
   logic [IDX_W-1:0]  xk_index;
   logic [DW-1:0]     xk_re;
   logic [DW-1:0]     xk_im;
   logic [2*DW-1:0]   sq_data;
   logic              sq_start;
   logic [DW-1:0]     sq_answer;
   logic              sq_done;
   logic [IDX_W-1:0]  haddr;
   logic [2:0]        hslot;
   logic [DW-1:0]     hdata;
   logic              hwe;
   logic              frame_done;
   logic              ovf;
   logic [7:0]        ovf_count;

   typedef struct {
      int slot;
      int idx;
      int mag;
   } wr_t;

   int   checks = 0;
   int   errors = 0;
   wr_t  wrQ[$];
   int   sqQ[$];
   bit   mTabEn[NBINS];
   int   mTabBin[NBINS];
   int   mDrops = 0;
   int   mIssued = 0;
   int   hweCount = 0;
   int   frameCount = 0;
   int   frameHweSnap = 0;
   bit   prevStart = 1'b0;
   int   sqCnt;
   logic [2*DW-1:0] sqRad;

   bin_mag_scheduler #(
      .NBINS(NBINS), .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W), .DW(DW), .FRAME_LAST(FRAME_LAST)
   ) dut (
      .clock_27mhz(clock_27mhz), .reset_n(reset_n),
      .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_bin(cfg_bin), .cfg_en(cfg_en),
      .xk_valid(xk_valid), .xk_index(xk_index), .xk_re(xk_re), .xk_im(xk_im),
      .sq_data(sq_data), .sq_start(sq_start), .sq_answer(sq_answer), .sq_done(sq_done),
      .haddr(haddr), .hslot(hslot), .hdata(hdata), .hwe(hwe),
      .frame_done(frame_done), .ovf(ovf), .ovf_count(ovf_count)
   );

   always #5 clock_27mhz = ~clock_27mhz;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Behavioural iterative sqrt: busy for DW cycles after a start, then done with the root
   always @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         sqCnt     <= 0;
         sqRad     <= '0;
         sq_answer <= '0;
      end else if (sq_start) begin
         sqCnt <= DW;
         sqRad <= sq_data;
      end else if (sqCnt > 0) begin
         sqCnt <= sqCnt - 1;
         if (sqCnt == 1) sq_answer <= DW'(isqrt(int'(sqRad)));
      end
   end

   assign sq_done = (sqCnt == 0);

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops expected radicands on sq_start and expected writes on hwe
   always @(negedge clock_27mhz) begin
      if (reset_n) begin
         if (sq_start) begin
            checkOutput("sq_start single cycle", prevStart, 0);
            if (sqQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected sq_start: sq_data %0d, nothing expected", sq_data);
            end else begin
               checkOutput("sq_data", sq_data, sqQ.pop_front());
            end
         end
         prevStart = sq_start;
         if (hwe) begin
            hweCount++;
            if (wrQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected hwe: haddr %0d hdata %0d, nothing expected", haddr, hdata);
            end else begin
               wr_t e;
               e = wrQ.pop_front();
               checkOutput("haddr", haddr, e.idx);
               checkOutput("hslot", hslot, e.slot);
               checkOutput("hdata", hdata, e.mag);
            end
         end
         if (frame_done) begin
            frameCount++;
            frameHweSnap = hweCount;
         end
      end else begin
         prevStart = 1'b0;
      end
   end

   // One cycle of stimulus plus the reference model's view of that cycle
   task automatic applyStimulus(input bit v, input int idx, input int re, input int im,
                                input bit we, input int slot, input int bin, input bit en);
      int hitSlot;
      int mag2;
      @(negedge clock_27mhz);
      xk_valid = v;
      xk_index = idx[IDX_W-1:0];
      xk_re    = re[DW-1:0];
      xk_im    = im[DW-1:0];
      cfg_we   = we;
      cfg_slot = slot[2:0];
      cfg_bin  = bin[IDX_W-1:0];
      cfg_en   = en;
      if (v) begin
         hitSlot = -1;
         for (int s = NBINS - 1; s >= 0; s--) begin
            if (mTabEn[s] && mTabBin[s] == idx) hitSlot = s;
         end
         if (hitSlot >= 0) begin
            mag2 = re * re + im * im;
            if (wrQ.size() < FIFO_DEPTH + 1) begin
               wrQ.push_back('{slot: hitSlot, idx: idx, mag: isqrt(mag2)});
               sqQ.push_back(mag2);
               mIssued++;
            end else begin
               mDrops++;
            end
         end
      end
      if (we) begin
         mTabEn[slot]  = en;
         mTabBin[slot] = bin;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock_27mhz);
         xk_valid = 1'b0;
         cfg_we   = 1'b0;
      end
   endtask

   task automatic programSlot(input int slot, input int bin, input bit en);
      applyStimulus(1'b0, 0, 0, 0, 1'b1, slot, bin, en);
   endtask

   task automatic clearTable();
      for (int s = 0; s < NBINS; s++) programSlot(s, 0, 1'b0);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      idleCycles(1);
      while ((wrQ.size() > 0 || sqQ.size() > 0) && n < 2000) begin
         idleCycles(1);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("[TB] FAIL %s drain timeout: %0d writes still expected, required 0", name, wrQ.size());
      end
      idleCycles(10);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " sq_start"}, sq_start, 0);
      checkOutput({tag, " sq_data"}, sq_data, 0);
      checkOutput({tag, " hwe"}, hwe, 0);
      checkOutput({tag, " haddr"}, haddr, 0);
      checkOutput({tag, " hslot"}, hslot, 0);
      checkOutput({tag, " hdata"}, hdata, 0);
      checkOutput({tag, " frame_done"}, frame_done, 0);
      checkOutput({tag, " ovf"}, ovf, 0);
      checkOutput({tag, " ovf_count"}, ovf_count, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      int fbase;
      int lastDrain;
      reset_n  = 1'b0;
      cfg_we   = 1'b0;
      cfg_slot = '0;
      cfg_bin  = '0;
      cfg_en   = 1'b0;
      xk_valid = 1'b0;
      xk_index = '0;
      xk_re    = '0;
      xk_im    = '0;
      for (int s = 0; s < NBINS; s++) begin
         mTabEn[s]  = 1'b0;
         mTabBin[s] = 0;
      end
      idleCycles(3);
      checkAllZero("reset");
      reset_n = 1'b1;
      idleCycles(2);

      // Test 1: single bin, 3-4-5 triangle
      base = hweCount;
      programSlot(0, 42, 1'b1);
      applyStimulus(1'b1, 42, 3, 4, 1'b0, 0, 0, 1'b0);
      waitDrain("t1");
      checkOutput("t1 writes", hweCount - base, 1);
      checkOutput("t1 hdata held", hdata, 5);
      checkOutput("t1 haddr held", haddr, 42);

      // Test 2: duplicate entries give one request from the lowest slot
      base = hweCount;
      programSlot(0, 0, 1'b0);
      programSlot(2, 'h11B, 1'b1);
      programSlot(5, 'h11B, 1'b1);
      applyStimulus(1'b1, 'h11B, -512, -512, 1'b0, 0, 0, 1'b0);
      waitDrain("t2");
      checkOutput("t2 writes", hweCount - base, 1);
      checkOutput("t2 hdata held", hdata, 724);
      checkOutput("t2 hslot held", hslot, 2);

      // Random phase: random tables and streams, bursts of at most FIFO_DEPTH+1 requests
      lastDrain = mIssued;
      for (int round = 0; round < 6; round++) begin
         for (int s = 0; s < NBINS; s++) begin
            programSlot(s, $urandom_range(0, 63), 1'($urandom_range(0, 1)));
         end
         for (int c = 0; c < 40; c++) begin
            bit we;
            if (mIssued - lastDrain >= FIFO_DEPTH + 1) begin
               waitDrain("random");
               lastDrain = mIssued;
            end
            we = ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 63),
                          int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
                          we, $urandom_range(0, NBINS - 1), $urandom_range(0, 63), 1'b1);
         end
         waitDrain("random");
         lastDrain = mIssued;
      end
      checkOutput("random ovf", ovf, mDrops > 0);
      checkOutput("random ovf_count", ovf_count, mDrops);
      checkOutput("no frame_done without last bin", frameCount, 0);

      // Test 4: table write and match in the same cycle uses the old table
      clearTable();
      base = hweCount;
      applyStimulus(1'b1, 20, 7, 0, 1'b1, 1, 20, 1'b1);
      idleCycles(30);
      checkOutput("t4 same-cycle no capture", hweCount - base, 0);
      applyStimulus(1'b1, 20, 7, 0, 1'b0, 0, 0, 1'b0);
      waitDrain("t4");
      checkOutput("t4 later capture", hweCount - base, 1);
      checkOutput("t4 hdata held", hdata, 7);

      // Test 3: six back-to-back captures overflow by one
      clearTable();
      for (int s = 0; s < 6; s++) programSlot(s, 10 + s, 1'b1);
      base = hweCount;
      for (int s = 0; s < 6; s++) applyStimulus(1'b1, 10 + s, 100, 100, 1'b0, 0, 0, 1'b0);
      waitDrain("t3");
      checkOutput("t3 writes", hweCount - base, 5);
      checkOutput("t3 ovf", ovf, 1);
      checkOutput("t3 ovf_count", ovf_count, mDrops);
      checkOutput("t3 hdata held", hdata, 141);

      // Test 5: frame_done follows the last write, once, even with a repeated last bin
      clearTable();
      programSlot(0, 30, 1'b1);
      programSlot(1, 31, 1'b1);
      base  = hweCount;
      fbase = frameCount;
      applyStimulus(1'b1, 30, 6, 8, 1'b0, 0, 0, 1'b0);
      applyStimulus(1'b1, 31, 0, -9, 1'b0, 0, 0, 1'b0);
      applyStimulus(1'b1, FRAME_LAST, 1, 1, 1'b0, 0, 0, 1'b0);
      applyStimulus(1'b1, FRAME_LAST, 1, 1, 1'b0, 0, 0, 1'b0);
      waitDrain("t5");
      idleCycles(20);
      checkOutput("t5 frame_done pulses", frameCount - fbase, 1);
      checkOutput("t5 frame_done after last write", frameHweSnap, base + 2);

      // Test 6: reset in the middle of a sqrt wait
      clearTable();
      programSlot(3, 50, 1'b1);
      applyStimulus(1'b1, 50, 1, 0, 1'b0, 0, 0, 1'b0);
      begin
         int n = 0;
         while (sqQ.size() > 0 && n < 30) begin
            idleCycles(1);
            n++;
         end
         checkOutput("t6 sq_start seen", sqQ.size(), 0);
      end
      idleCycles(4);
      reset_n = 1'b0;
      #1;
      checkAllZero("t6 reset");
      wrQ.delete();
      sqQ.delete();
      mDrops = 0;
      for (int s = 0; s < NBINS; s++) mTabEn[s] = 1'b0;
      idleCycles(2);
      reset_n = 1'b1;
      base = hweCount;
      applyStimulus(1'b1, 50, 1, 0, 1'b0, 0, 0, 1'b0);
      idleCycles(40);
      checkOutput("t6 no write after reset", hweCount - base, 0);
      checkOutput("t6 ovf cleared", ovf, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
